// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU exception-status slice.
// Exception bit positions, the status FSM encoding and FP class codes.
package fpu_pkg;

  // Exception kinds and their bit positions in an exception vector
  localparam int NEXC             = 5;
  localparam int EXC_INVALID      = 0;
  localparam int EXC_DIVIDEBYZERO = 1;
  localparam int EXC_OVERFLOW     = 2;
  localparam int EXC_UNDERFLOW    = 3;
  localparam int EXC_INEXACT      = 4;

  // Read-port FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // FP operand class codes, kept next to the exception constants
  typedef enum logic [2:0] {
    CLS_NORMAL    = 3'd0,
    CLS_SUBNORMAL = 3'd1,
    CLS_ZERO      = 3'd2,
    CLS_INF       = 3'd3,
    CLS_QNAN      = 3'd4,
    CLS_SNAN      = 3'd5
  } fp_class_e;

endpackage

// File: rtl/fpu_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count one event),
//        clr (synchronous clear, wins over inc), count (current value).
module fpu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_exception_status.sv
// FPU exception status collector.
// Accumulates per-operation exception vectors into sticky bits and
// per-exception saturating counters; offers a read / read-and-clear port
// and an interrupt gated by a software enable mask.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   op_valid/op_ready       exception vector handshake from the FPU
//   op_flags                exception bits of one completed operation
//   en_we/en_wdata/en_mask  interrupt enable mask write port and readback
//   rd_req/rd_clear/rd_sel  read request, clear-on-read, counter select
//   rd_ack                  one-cycle pulse, snapshot outputs valid
//   rd_flags/rd_count       sticky snapshot and counter[rd_sel] snapshot
//   irq                     any enabled sticky bit set
//
// state      | meaning
// IDLE       | accepting vectors, waiting for rd_req
// CAPTURE    | vectors frozen, snapshot taken
// RESPOND    | vectors frozen, rd_ack high, optional clear
module fpu_exception_status #(
  parameter int NEXC  = fpu_pkg::NEXC,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [NEXC-1:0]         op_flags,
  input  logic                    en_we,
  input  logic [NEXC-1:0]         en_wdata,
  output logic [NEXC-1:0]         en_mask,
  input  logic                    rd_req,
  input  logic                    rd_clear,
  input  logic [$clog2(NEXC)-1:0] rd_sel,
  output logic                    rd_ack,
  output logic [NEXC-1:0]         rd_flags,
  output logic [CNT_W-1:0]        rd_count,
  output logic                    irq
);

  import fpu_pkg::*;

  logic [1:0]              state;
  logic                    clear_q;
  logic [$clog2(NEXC)-1:0] sel_q;
  logic [NEXC-1:0]         sticky;
  logic [CNT_W-1:0]        cnt [NEXC];
  logic [CNT_W-1:0]        sel_cnt;
  logic                    accept;
  logic                    clr_all;

  // Vectors are only consumed in IDLE, so a clearing RESPOND can never
  // race against a set in the same cycle.
  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid & op_ready;
  assign rd_ack   = (state == ST_RESPOND);
  assign clr_all  = (state == ST_RESPOND) & clear_q;
  assign irq      = |(sticky & en_mask);

  for (genvar g = 0; g < NEXC; g++) begin : g_cnt
    fpu_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept & op_flags[g]),
      .clr   (clr_all),
      .count (cnt[g])
    );
  end

  // Out-of-range selects match no counter and read as zero.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NEXC; i++) begin
      if (int'(sel_q) == i) sel_cnt = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else if (clr_all) begin
      sticky <= '0;
    end else if (accept) begin
      sticky <= sticky | op_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_mask <= '0;
    end else if (en_we) begin
      en_mask <= en_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clear_q  <= 1'b0;
      sel_q    <= '0;
      rd_flags <= '0;
      rd_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            clear_q <= rd_clear;
            sel_q   <= rd_sel;
            state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          rd_flags <= sticky;
          rd_count <= sel_cnt;
          state    <= ST_RESPOND;
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_exception_status.md
Name: fpu_exception_status

Overview:
Consumer end of the FPU exception-flag interface. Accepts one 5-bit exception vector per completed FP operation and accumulates it into sticky status bits, with per-exception saturating event counters. Exposes a software read / read-and-clear port and an interrupt line gated by an enable mask. Sits between the FPU result stage and the control/CSR block.

Parameters:
NEXC, 5, number of exception kinds; bit order INVALID=0, DIVIDEBYZERO=1, OVERFLOW=2, UNDERFLOW=3, INEXACT=4
CNT_W, 16, width of each per-exception event counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  exception vector from FPU valid
op_ready  out  1  block can accept a vector
op_flags  in  NEXC  exception bits of one completed operation
en_we  in  1  write strobe for interrupt enable mask
en_wdata  in  NEXC  new enable mask
en_mask  out  NEXC  current enable mask
rd_req  in  1  single-cycle read request pulse
rd_clear  in  1  sampled with rd_req; 1 = read-and-clear
rd_sel  in  $clog2(NEXC)  counter index sampled with rd_req
rd_ack  out  1  one-cycle pulse, rd_flags/rd_count valid
rd_flags  out  NEXC  snapshot of sticky bits
rd_count  out  CNT_W  snapshot of counter[rd_sel]
irq  out  1  |(sticky & en_mask)

Behaviour:
- Reset (async, rst_n=0): sticky=0, all counters=0, en_mask=0, rd_flags=0, rd_count=0, rd_ack=0, irq=0, FSM=IDLE, op_ready=1 after release.
- FSM states: IDLE, CAPTURE, RESPOND.
- IDLE: op_ready=1. rd_req=1 -> CAPTURE; latch rd_clear and rd_sel into internal regs.
- CAPTURE: op_ready=0; rd_flags<=sticky, rd_count<=counter[sel_q]; -> RESPOND.
- RESPOND: op_ready=0; rd_ack=1 (this cycle only). If clear_q: sticky<=0 and all counters<=0 at end of cycle. -> IDLE.
- Read latency: rd_req at cycle t -> rd_ack at t+2; op_ready low in t+1 and t+2. This freeze prevents set/clear races.
- rd_req outside IDLE is ignored (no queueing). rd_clear and rd_sel are don't-care without rd_req.
- rd_sel >= NEXC: rd_count snapshot = 0.
- Op accept: handshake op_valid & op_ready at cycle t.
  - sticky |= op_flags at t+1.
  - Each counter[i] with op_flags[i]=1 increments by 1 at t+1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - op_flags=0 is accepted with no state change.
  - op_valid while op_ready=0: vector not consumed; the FPU holds it stable until accepted.
- rd_flags/rd_count hold their values until the next CAPTURE.
- en_we is accepted in any state; en_mask updates at next edge.
- irq is combinational from registered sticky and en_mask, so it is glitch-free. It asserts the cycle after the causing accept or en_we and deasserts the cycle after a clearing RESPOND. en_we and a clearing RESPOND in the same cycle both take effect.
- Reset mid-read: FSM returns to IDLE, no rd_ack is produced, and all state is zeroed.

Decomposition:
- Shared package fpu_pkg:
  - exception index constants INVALID..INEXACT and NEXC=5
  - FSM state encoding
  - class codes NORMAL..SNAN, kept co-located with the exception constants
- One sub-module fpu_sat_counter (CNT_W param; inc, clr, count). Instantiated NEXC times via generate.

Test Plan:
- Reset then idle: op_ready=1, irq=0, rd_flags=0, en_mask=0.
- Accept op_flags=5'b10001, then 5'b10000; read with rd_clear=0, rd_sel=4 -> rd_ack at t+2, rd_flags=5'b10001, rd_count=2. A second identical read returns the same values.
- en_wdata=5'b00100, then op_flags=5'b00100 -> irq=1 the cycle after accept. Read-and-clear -> rd_flags=5'b00100; irq=0 and counters=0 the cycle after rd_ack.
- op_valid held high with op_flags=5'b00010 across a read: op_ready low exactly 2 cycles. The vector is counted once, after the clear: counter[1]=1 and sticky[1]=1 post-clear.
- Preload counter[0] to 2^CNT_W-2 (CNT_W=4 build); accept 3 INVALID ops -> rd_count=15.
- rst_n asserted in CAPTURE -> no rd_ack; sticky, counters and en_mask all 0; normal accept works after release.
